// File: rtl/spi_xfer_ctrl_if.sv
// Peripheral-bus port bundle for the SPI transfer controller.
// The slave modport is the controller side; the master modport is the CPU/bus side.
interface spi_xfer_ctrl_if #(
   parameter int unsigned AW = 5
) ();

   logic          we_i;
   logic          re_i;
   logic [AW-1:0] addr_i;
   logic [31:0]   wdata_i;
   logic [31:0]   rdata_o;

   modport slave (
      input  we_i,
      input  re_i,
      input  addr_i,
      input  wdata_i,
      output rdata_o
   );

   modport master (
      output we_i,
      output re_i,
      output addr_i,
      output wdata_i,
      input  rdata_o
   );

endinterface

// File: rtl/spi_xfer_ctrl.sv
// Memory-mapped SPI master (mode 0, MSB first): bursts a byte buffer out over
// mosi_po and writes the received bytes back into the same buffer entries.
module spi_xfer_ctrl #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned AW      = $clog2(DEPTH) + 1
) (
   input  logic           clk_pi,
   input  logic           reset_pi,
   spi_xfer_ctrl_if.slave bus,
   input  logic           miso_pi,
   output logic           sclk_po,
   output logic           mosi_po,
   output logic           cs_po,
   output logic           done_o
);

   localparam int unsigned IW = AW - 1;
   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT_HI,
      SHIFT_LO,
      CS_HOLD
   } state_t;

   state_t          state_q;
   state_t          state_nx;
   logic [CW-1:0]   cnt_q;
   logic [IW-1:0]   idx_q;
   logic [IW-1:0]   n_q;
   logic [2:0]      bit_q;
   logic [7:0]      sr_q;
   logic            final_q;
   logic            done_q;
   logic            sclk_q;
   logic            mosi_q;
   logic            cs_q;
   logic [31:0]     rdata_q;
   logic [7:0]      mem [DEPTH];

   logic            busy;
   logic            sel_buf;
   logic [IW-1:0]   bidx;
   logic            ctrl_wr;
   logic            start_acc;
   logic            buf_wr;
   logic [IW-1:0]   n_sat;
   logic            cnt_last;
   logic            byte_end;
   logic [IW-1:0]   nxt_idx;
   logic [31:0]     ctrl_rd;
   logic            unused_wdata;

   // Bus decode; starts and buffer writes are only honoured while idle
   assign busy      = (state_q != IDLE);
   assign sel_buf   = bus.addr_i[AW-1];
   assign bidx      = bus.addr_i[IW-1:0];
   assign ctrl_wr   = bus.we_i && !sel_buf && !busy;
   assign start_acc = ctrl_wr && bus.wdata_i[0];
   assign buf_wr    = bus.we_i && sel_buf && !busy;
   assign n_sat     = ({1'b0, bus.wdata_i[11:4]} >= 9'(DEPTH)) ? IW'(DEPTH - 1)
                                                             : IW'(bus.wdata_i[11:4]);
   assign unused_wdata = ^{bus.wdata_i[31:12], bus.wdata_i[3:1]};

   assign cnt_last = (cnt_q == CW'(CLK_DIV - 1));
   assign byte_end = (state_q == SHIFT_HI) && cnt_last && (bit_q == 3'd0);
   assign nxt_idx  = idx_q + IW'(1);
   assign ctrl_rd  = {20'd0, 8'(n_q), 1'b0, done_q, 1'b0, busy};

   // State register
   always_ff @(posedge clk_pi) begin
      if (reset_pi) state_q <= IDLE;
      else          state_q <= state_nx;
   end

   // Next-state logic: every non-idle phase lasts CLK_DIV cycles
   always_comb begin
      state_nx = state_q;
      case (state_q)
         IDLE:     if (start_acc) state_nx = CS_SETUP;
         CS_SETUP: if (cnt_last)  state_nx = SHIFT_HI;
         SHIFT_HI: if (cnt_last)  state_nx = SHIFT_LO;
         SHIFT_LO: if (cnt_last)  state_nx = final_q ? CS_HOLD : SHIFT_HI;
         CS_HOLD:  if (cnt_last)  state_nx = IDLE;
         default:                 state_nx = IDLE;
      endcase
   end

   // Datapath, pin registers and bus read port
   always_ff @(posedge clk_pi) begin
      if (reset_pi) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         n_q     <= '0;
         bit_q   <= 3'd0;
         sr_q    <= 8'd0;
         final_q <= 1'b0;
         done_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_q    <= 1'b1;
         rdata_q <= 32'd0;
      end else begin
         cnt_q  <= ((state_nx != state_q) || (state_q == IDLE)) ? '0 : cnt_q + CW'(1);
         cs_q   <= (state_nx == IDLE);
         sclk_q <= (state_nx == SHIFT_HI);

         if (ctrl_wr) n_q <= n_sat;

         if (start_acc) begin
            idx_q   <= '0;
            bit_q   <= 3'd7;
            sr_q    <= mem[0];
            mosi_q  <= mem[0][7];
            final_q <= 1'b0;
            done_q  <= 1'b0;
         end

         // Rising sclk: sample miso; sr_q[7] then already holds the next tx bit
         if ((state_nx == SHIFT_HI) && (state_q != SHIFT_HI))
            sr_q <= {sr_q[6:0], miso_pi};

         // Falling sclk: advance to the next bit, or close out the byte
         if ((state_q == SHIFT_HI) && cnt_last) begin
            if (bit_q != 3'd0) begin
               bit_q  <= bit_q - 3'd1;
               mosi_q <= sr_q[7];
            end else if (idx_q == n_q) begin
               final_q <= 1'b1;
               mosi_q  <= 1'b0;
            end else begin
               idx_q  <= nxt_idx;
               bit_q  <= 3'd7;
               sr_q   <= mem[nxt_idx];
               mosi_q <= mem[nxt_idx][7];
            end
         end

         if ((state_q == CS_HOLD) && cnt_last) done_q <= 1'b1;

         if (bus.re_i) rdata_q <= sel_buf ? {24'd0, mem[bidx]} : ctrl_rd;
      end
   end

   // Byte buffer (not reset); a received byte replaces its tx byte at byte end
   always_ff @(posedge clk_pi) begin
      if (!reset_pi) begin
         if (byte_end)    mem[idx_q] <= sr_q;
         else if (buf_wr) mem[bidx]  <= bus.wdata_i[7:0];
      end
   end

   assign sclk_po     = sclk_q;
   assign mosi_po     = mosi_q;
   assign cs_po       = cs_q;
   assign done_o      = done_q;
   assign bus.rdata_o = rdata_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: a bus vector table for idle register/buffer
// access, then hand-written burst sequences with cycle-indexed mid-burst actions.
module tb_spi_xfer_ctrl;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned DEPTH   = 16;
   localparam int unsigned AW      = 5;
   localparam logic [AW-1:0] CTRL  = 5'h00;

   logic clk = 1'b0;
   logic reset;
   logic loop_en, miso_val, miso, sclk, mosi, cs, done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   spi_xfer_ctrl_if #(.AW(AW)) bus ();

   assign miso = loop_en ? mosi : miso_val;

   spi_xfer_ctrl #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk_pi   (clk),
      .reset_pi (reset),
      .bus      (bus),
      .miso_pi  (miso),
      .sclk_po  (sclk),
      .mosi_po  (mosi),
      .cs_po    (cs),
      .done_o   (done)
   );

   typedef struct {
      logic          we;
      logic          re;
      logic [AW-1:0] addr;
      logic [31:0]   wd;
      logic          chk;
      logic [31:0]   exp;
      string         name;
   } vec_t;

   typedef struct {
      int            cyc;
      logic          rst;
      logic          we;
      logic          re;
      logic [AW-1:0] addr;
      logic [31:0]   wd;
      logic          chk;
      logic [31:0]   exp;
   } act_t;

   vec_t vecs[$];
   act_t acts[$];

   function automatic logic [AW-1:0] baddr(input int i);
      return AW'(16 + i);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_bus();
      bus.we_i    = 1'b0;
      bus.re_i    = 1'b0;
      bus.addr_i  = '0;
      bus.wdata_i = 32'd0;
      reset       = 1'b0;
   endtask

   task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
      bus.we_i = 1'b1; bus.addr_i = a; bus.wdata_i = d;
      tick();
      clear_bus();
   endtask

   task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
      bus.re_i = 1'b1; bus.addr_i = a;
      tick();
      clear_bus();
      d = bus.rdata_o;
   endtask

   task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(a, d);
      chk(name, d, exp);
   endtask

   task automatic add_act(input int c, input logic r, input logic w, input logic rd,
                          input logic [AW-1:0] a, input logic [31:0] d,
                          input logic ck, input logic [31:0] e);
      act_t t;
      t.cyc = c; t.rst = r; t.we = w; t.re = rd; t.addr = a; t.wd = d; t.chk = ck; t.exp = e;
      acts.push_back(t);
   endtask

   // Follows a burst from the cycle after its start write until cs_po rises
   task automatic run_burst(input string name, input int exp_cyc, input int exp_rises,
                            input logic chk_mosi, input logic [31:0] exp_mosi);
      int          cyc   = 0;
      int          rises = 0;
      logic [31:0] bits  = 32'd0;
      logic        prev;
      while (cs === 1'b0 && cyc < 3000) begin
         prev = sclk;
         foreach (acts[k]) begin
            if (acts[k].cyc == cyc) begin
               reset       = acts[k].rst;
               bus.we_i    = acts[k].we;
               bus.re_i    = acts[k].re;
               bus.addr_i  = acts[k].addr;
               bus.wdata_i = acts[k].wd;
            end
         end
         tick();
         clear_bus();
         foreach (acts[k])
            if (acts[k].cyc == cyc && acts[k].chk)
               chk($sformatf("%s_act%0d", name, cyc), bus.rdata_o, acts[k].exp);
         if (!prev && sclk) begin
            rises++;
            bits = {bits[30:0], mosi};
         end
         cyc++;
      end
      if (cyc >= 3000) chk({name, "_timeout"}, 32'(cyc), 32'(exp_cyc));
      chk({name, "_busy_cycles"}, 32'(cyc), 32'(exp_cyc));
      chk({name, "_sclk_rises"}, 32'(rises), 32'(exp_rises));
      if (chk_mosi) chk({name, "_mosi_bits"}, bits, exp_mosi);
      acts.delete();
   endtask

   task automatic add_vec(input logic w, input logic r, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic ck, input logic [31:0] e,
                          input string n);
      vec_t v;
      v.we = w; v.re = r; v.addr = a; v.wd = d; v.chk = ck; v.exp = e; v.name = n;
      vecs.push_back(v);
   endtask

   initial begin
      loop_en  = 1'b0;
      miso_val = 1'b0;
      clear_bus();
      reset = 1'b1;
      repeat (3) tick();
      chk("rst_cs", 32'(cs), 32'd1);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rdata", bus.rdata_o, 32'd0);
      reset = 1'b0;

      // Idle bus access
      add_vec(1'b0, 1'b1, CTRL,     32'h0,   1'b1, 32'h0,  "rd_ctrl_after_rst");
      add_vec(1'b1, 1'b0, baddr(3), 32'h1C7, 1'b0, 32'h0,  "wr_buf3");
      add_vec(1'b1, 1'b0, baddr(15),32'hAB,  1'b0, 32'h0,  "wr_buf15");
      add_vec(1'b0, 1'b1, baddr(3), 32'h0,   1'b1, 32'hC7, "rd_buf3");
      add_vec(1'b0, 1'b1, baddr(15),32'h0,   1'b1, 32'hAB, "rd_buf15");
      add_vec(1'b1, 1'b0, baddr(3), 32'h0,   1'b0, 32'h0,  "wr_buf3_zero");
      add_vec(1'b0, 1'b1, baddr(3), 32'h0,   1'b1, 32'h0,  "rd_buf3_zero");
      add_vec(1'b0, 1'b1, baddr(15),32'h0,   1'b1, 32'hAB, "rd_buf15_again");
      for (int i = 0; i < vecs.size(); i++) begin
         bus.we_i = vecs[i].we; bus.re_i = vecs[i].re;
         bus.addr_i = vecs[i].addr; bus.wdata_i = vecs[i].wd;
         tick();
         clear_bus();
         if (vecs[i].chk) chk(vecs[i].name, bus.rdata_o, vecs[i].exp);
      end

      // Loopback single byte; CTRL read in the completion cycle sees pre-update value
      loop_en = 1'b1;
      bus_write(baddr(0), 32'hA5);
      add_act(71, 1'b0, 1'b0, 1'b1, CTRL, 32'h0, 1'b1, 32'h001);
      bus_write(CTRL, 32'h001);
      chk("lb_cs_low", 32'(cs), 32'd0);
      chk("lb_done_clr", 32'(done), 32'd0);
      run_burst("lb", 72, 8, 1'b1, 32'hA5);
      chk("lb_done", 32'(done), 32'd1);
      chk("lb_cs_high", 32'(cs), 32'd1);
      read_chk("lb_buf0", baddr(0), 32'hA5);
      read_chk("lb_ctrl", CTRL, 32'h004);

      // Three bytes, miso held high
      loop_en  = 1'b0;
      miso_val = 1'b1;
      bus_write(baddr(0), 32'h00);
      bus_write(baddr(1), 32'h3C);
      bus_write(baddr(2), 32'h81);
      bus_write(CTRL, 32'h021);
      run_burst("b3", 200, 24, 1'b1, 32'h003C81);
      for (int i = 0; i < 3; i++) read_chk($sformatf("b3_buf%0d", i), baddr(i), 32'hFF);
      read_chk("b3_ctrl", CTRL, 32'h024);

      // Oversized length saturates to DEPTH-1
      miso_val = 1'b0;
      add_act(5, 1'b0, 1'b0, 1'b1, CTRL, 32'h0, 1'b1, 32'h0F1);
      bus_write(CTRL, 32'hC81);
      run_burst("sat", 1032, 128, 1'b0, 32'h0);
      read_chk("sat_ctrl", CTRL, 32'h0F4);

      // Writes during a burst are ignored, including a start at completion
      bus_write(baddr(0), 32'h12);
      add_act(10, 1'b0, 1'b1, 1'b0, baddr(0), 32'h55, 1'b0, 32'h0);
      add_act(11, 1'b0, 1'b1, 1'b0, CTRL, 32'h051, 1'b0, 32'h0);
      add_act(12, 1'b0, 1'b0, 1'b1, baddr(0), 32'h0, 1'b1, 32'h12);
      add_act(13, 1'b0, 1'b0, 1'b1, CTRL, 32'h0, 1'b1, 32'h001);
      add_act(71, 1'b0, 1'b1, 1'b0, CTRL, 32'h011, 1'b0, 32'h0);
      bus_write(CTRL, 32'h001);
      run_burst("ign", 72, 8, 1'b1, 32'h12);
      tick();
      chk("ign_no_restart", 32'(cs), 32'd1);
      chk("ign_done", 32'(done), 32'd1);
      read_chk("ign_ctrl", CTRL, 32'h004);
      read_chk("ign_buf0", baddr(0), 32'h00);

      // Reset at byte 1, bit 3 aborts; byte 1 is not written back
      loop_en = 1'b1;
      bus_write(baddr(0), 32'h5A);
      bus_write(baddr(1), 32'hC3);
      add_act(100, 1'b1, 1'b0, 1'b0, CTRL, 32'h0, 1'b0, 32'h0);
      bus_write(CTRL, 32'h011);
      run_burst("rst", 101, 13, 1'b1, 32'hB58);
      chk("rst_mid_sclk", 32'(sclk), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      read_chk("rst_mid_ctrl", CTRL, 32'h000);
      read_chk("rst_mid_buf1", baddr(1), 32'hC3);
      bus_write(CTRL, 32'h001);
      run_burst("post_rst", 72, 8, 1'b1, 32'h5A);
      chk("post_rst_done", 32'(done), 32'd1);

      // Back-to-back start in the cycle busy falls
      bus_write(CTRL, 32'h001);
      chk("b2b_cs_low", 32'(cs), 32'd0);
      chk("b2b_done_clr", 32'(done), 32'd0);
      run_burst("b2b", 72, 8, 1'b1, 32'h5A);
      chk("b2b_done", 32'(done), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
